sap_param_sequencer: RTL and testbench
======================================

Name: sap_param_sequencer

Overview:
Parametrised successor to the fixed 6-state control sequencer in the SAP CPU. It generates the per-T-state control word for fetch and execute over a configurable ring length. It adds variable-length instructions with early end, run/stall gating, a HALT state, and an instr_done strobe. It drives the PC, MAR, RAM, IR, A, TMP, B, ALU and output-register enables.

Parameters:
OPCODE_W, 4, opcode width; defined opcodes use low 4 bits, upper bits must be 0 or the opcode decodes as NOP
T_MAX, 6, ring length in T-states; legal range 6..8
EARLY_END, 1, 1 = return to T1 after an instruction's last active state; 0 = always run T1..T_MAX
HLT_OPCODE, 4'hF, opcode that enters HALT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  1 = advance one T-state per cycle; 0 = stall
opcode  in  OPCODE_W  IR opcode field; sampled from T4 onward
ctrl  out  19  control word; bit order {Cp,Ep,Lmp,Lmi,Cei,Cea,Li,Ei,LaRam,Lab,Lalu,Eatmp,Ltmpa,Lbtmp,Etmpb,Eba,Su,Eu,Lo}, Cp = bit 18
t_state  out  T_MAX  one-hot current T-state, bit0 = T1
instr_done  out  1  high during the final T-state of every instruction
halted  out  1  high while in HALT

Behaviour:
- State register: one-hot ring T1..T_MAX plus HALT. ctrl is a combinational decode of the registered state and opcode. All other outputs derive from state.
- Reset: next edge gives T1, t_state=1, halted=0. While reset=1, ctrl=0 and instr_done=0. Reset mid-instruction abandons it; no partial completion. Reset also exits HALT.
- run=0: state holds, ctrl forced to 0, instr_done=0. run=1: state advances one step per cycle. Reset has priority over run.
- Fetch, identical for all opcodes:
  - T1: Ep, Lmp
  - T2: Cp
  - T3: Cei, Li
- Execute (opcode 4-bit value / last active state):
  - 0000 LDA: T4 Lmi,Ei; T5 Cea,LaRam. Last = T5.
  - 0001 XCHG: T4 Eatmp,Ltmpa; T5 Eba,Lab; T6 Etmpb,Lbtmp. Last = T6.
  - 0010 ADD: T4 Eu,Lalu. Last = T4.
  - 0011 SUB: T4 Su,Eu,Lalu. Last = T4.
  - 0100 MOVB: T4 Eatmp,Ltmpa; T5 Etmpb,Lbtmp. Last = T5.
  - 1110 OUT: T4 Lo. Last = T4.
  - HLT_OPCODE at T4: ctrl=0; next state is HALT.
  - All other opcodes (NOP): ctrl=0; last = T4.
- States beyond an instruction's last active state, reachable only with EARLY_END=0, output ctrl=0.
- Next state, EARLY_END=1: last active state goes to T1; otherwise advance to the next state.
- Next state, EARLY_END=0: T_MAX goes to T1; otherwise advance.
- instr_done: high in the last active state (EARLY_END=1) or in T_MAX (EARLY_END=0). Never high in T1..T3 or HALT.
- HALT: ctrl=0, t_state=0, halted=1, instr_done=0. Held regardless of run until reset.
- No two of {LaRam, Lab, Lalu} are ever asserted in the same cycle. Only one bus driver {Ei, Cea, Eba, Etmpb, Eatmp, Eu} is active per cycle; this is asserted in RTL.
- Opcode must be stable from T4 to the end of the instruction. A change mid-execute is not defended against.

Decomposition:
- Package sap_pkg holds:
  - opcode localparams: OP_LDA, OP_XCHG, OP_ADD, OP_SUB, OP_MOVB, OP_OUT, OP_HLT
  - CTRL_W=19 and per-bit index constants
  - a helper function returning each opcode's last active T-state
- Sub-module sap_instr_decoder (combinational): maps {t_state, opcode} to ctrl and last_state. sap_param_sequencer owns the ring and HALT register.

Test Plan:
- Reset held 2 cycles, then run=1, opcode=0000 → ctrl sequence 0, Ep|Lmp, Cp, Cei|Li, Lmi|Ei, Cea|LaRam; instr_done in the T5 cycle; t_state=000001 next.
- opcode=0001 with EARLY_END=1 → T4..T6 give Eatmp|Ltmpa, Eba|Lab, Etmpb|Lbtmp; 6-cycle instruction; instr_done at T6.
- opcode=0010, EARLY_END=1 then EARLY_END=0 with T_MAX=8 → 4-cycle instruction vs 8-cycle instruction; T5..T8 ctrl=0; instr_done only at T8.
- run deasserted for 3 cycles at T2 → t_state stays 000010 and ctrl=0 throughout; resumes with Cp on the first run=1 cycle.
- opcode=1111 → HALT after T4: halted=1, ctrl=0 for 20 cycles with run toggling; reset → T1 on the next edge.
- Reset asserted at T5 of XCHG → no Lab and no Lbtmp seen; T1 follows; OPCODE_W=6 with opcode 6'b010001 → NOP behaviour.

Source files
------------

// File: rtl/sap_pkg.sv
// SAP parametrised sequencer: shared opcodes,
// control-word bit indices and per-opcode helpers.
package sap_pkg;

  localparam int CTRL_W = 19;

  localparam int B_CP    = 18;
  localparam int B_EP    = 17;
  localparam int B_LMP   = 16;
  localparam int B_LMI   = 15;
  localparam int B_CEI   = 14;
  localparam int B_CEA   = 13;
  localparam int B_LI    = 12;
  localparam int B_EI    = 11;
  localparam int B_LARAM = 10;
  localparam int B_LAB   = 9;
  localparam int B_LALU  = 8;
  localparam int B_EATMP = 7;
  localparam int B_LTMPA = 6;
  localparam int B_LBTMP = 5;
  localparam int B_ETMPB = 4;
  localparam int B_EBA   = 3;
  localparam int B_SU    = 2;
  localparam int B_EU    = 1;
  localparam int B_LO    = 0;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_XCHG = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MOVB = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic {
    MODE_RING,
    MODE_HALT
  } mode_e;

  // Last T-state (1-based) that does work;
  // anything undefined behaves as a 4-state NOP.
  function automatic int unsigned last_t(
    input logic [3:0] op
  );
    case (op)
      OP_LDA:  return 5;
      OP_XCHG: return 6;
      OP_MOVB: return 5;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/sap_instr_decoder.sv
// SAP instruction decoder: one-hot T-state plus
// opcode to control word and last-state flag.
module sap_instr_decoder
  import sap_pkg::*;
#(
  parameter int          OPCODE_W   = 4,
  parameter int          T_MAX      = 6,
  parameter int unsigned HLT_OPCODE = 4'hF
) (
  input  logic [T_MAX-1:0]    t_state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                last_o,
  output logic                hlt_o
);

  logic [3:0]  op4;
  logic        legal;
  logic        exec;
  int unsigned lt;

  // Opcode qualification and last-state lookup.
  always_comb begin
    op4   = opcode_i[3:0];
    legal = ((opcode_i >> 4) == '0);
    hlt_o = (opcode_i == OPCODE_W'(HLT_OPCODE));
    exec  = legal && !hlt_o;
    lt    = exec ? last_t(op4) : 4;
    last_o = t_state_i[3'(lt - 1)];
  end

  // Control word for fetch and execute states.
  always_comb begin
    ctrl_o = '0;
    unique case (1'b1)
      t_state_i[0]: begin
        ctrl_o[B_EP]  = 1'b1;
        ctrl_o[B_LMP] = 1'b1;
      end
      t_state_i[1]: ctrl_o[B_CP] = 1'b1;
      t_state_i[2]: begin
        ctrl_o[B_CEI] = 1'b1;
        ctrl_o[B_LI]  = 1'b1;
      end
      t_state_i[3]: if (exec) begin
        case (op4)
          OP_LDA: begin
            ctrl_o[B_LMI] = 1'b1;
            ctrl_o[B_EI]  = 1'b1;
          end
          OP_XCHG, OP_MOVB: begin
            ctrl_o[B_EATMP] = 1'b1;
            ctrl_o[B_LTMPA] = 1'b1;
          end
          OP_ADD: begin
            ctrl_o[B_EU]   = 1'b1;
            ctrl_o[B_LALU] = 1'b1;
          end
          OP_SUB: begin
            ctrl_o[B_SU]   = 1'b1;
            ctrl_o[B_EU]   = 1'b1;
            ctrl_o[B_LALU] = 1'b1;
          end
          OP_OUT: ctrl_o[B_LO] = 1'b1;
          default: ;
        endcase
      end
      t_state_i[4]: if (exec) begin
        case (op4)
          OP_LDA: begin
            ctrl_o[B_CEA]   = 1'b1;
            ctrl_o[B_LARAM] = 1'b1;
          end
          OP_XCHG: begin
            ctrl_o[B_EBA] = 1'b1;
            ctrl_o[B_LAB] = 1'b1;
          end
          OP_MOVB: begin
            ctrl_o[B_ETMPB] = 1'b1;
            ctrl_o[B_LBTMP] = 1'b1;
          end
          default: ;
        endcase
      end
      t_state_i[5]: if (exec && op4 == OP_XCHG) begin
        ctrl_o[B_ETMPB] = 1'b1;
        ctrl_o[B_LBTMP] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_param_sequencer.sv
// SAP parametrised sequencer: one-hot T-state
// ring with HALT, run gating and done strobe.
module sap_param_sequencer
  import sap_pkg::*;
#(
  parameter int          OPCODE_W   = 4,
  parameter int          T_MAX      = 6,
  parameter bit          EARLY_END  = 1'b1,
  parameter int unsigned HLT_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [T_MAX-1:0]    t_state,
  output logic                instr_done,
  output logic                halted
);

  if (T_MAX < 6 || T_MAX > 8) begin : g_bad_tmax
    $error("T_MAX must be 6..8");
  end

  mode_e            mode_q, mode_d;
  logic [T_MAX-1:0] ring_q, ring_d;
  logic [CTRL_W-1:0] dec_ctrl;
  logic             last;
  logic             hlt_op;
  logic             hlt_now;
  logic             fin;
  logic             active;

  sap_instr_decoder #(
    .OPCODE_W   (OPCODE_W),
    .T_MAX      (T_MAX),
    .HLT_OPCODE (HLT_OPCODE)
  ) u_dec (
    .t_state_i (ring_q),
    .opcode_i  (opcode),
    .ctrl_o    (dec_ctrl),
    .last_o    (last),
    .hlt_o     (hlt_op)
  );

  // Next state: advance, wrap at instruction end, or halt.
  always_comb begin
    active  = run && !reset && (mode_q == MODE_RING);
    hlt_now = ring_q[3] && hlt_op;
    fin     = hlt_now ||
              (EARLY_END ? last : ring_q[T_MAX-1]);
    ring_d  = ring_q;
    mode_d  = mode_q;
    if (active) begin
      if (hlt_now) begin
        ring_d = '0;
        mode_d = MODE_HALT;
      end else if (fin) begin
        ring_d = T_MAX'(1);
      end else begin
        ring_d = {ring_q[T_MAX-2:0], 1'b0};
      end
    end
  end

  // State register; reset restarts at T1 and leaves HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      ring_q <= T_MAX'(1);
      mode_q <= MODE_RING;
    end else begin
      ring_q <= ring_d;
      mode_q <= mode_d;
    end
  end

  // Outputs are silent during reset, stall and HALT.
  always_comb begin
    ctrl       = active ? dec_ctrl : '0;
    t_state    = ring_q;
    instr_done = active && fin;
    halted     = (mode_q == MODE_HALT);
  end

  a_one_driver: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0({ctrl[B_EI], ctrl[B_CEA], ctrl[B_EBA],
              ctrl[B_ETMPB], ctrl[B_EATMP], ctrl[B_EU]})
  ) else $error("multiple bus drivers");

  a_one_a_load: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0({ctrl[B_LARAM], ctrl[B_LAB], ctrl[B_LALU]})
  ) else $error("multiple A-register loads");

endmodule

// File: tb/tb_sap_param_sequencer.sv
// Bench for sap_param_sequencer: three configurations
// checked against a cycle model via a scoreboard queue.
module tb_sap_param_sequencer;

  localparam int CP = 18, EP = 17, LMP = 16, LMI = 15;
  localparam int CEI = 14, CEA = 13, LI = 12, EI = 11;
  localparam int LARAM = 10, LAB = 9, LALU = 8;
  localparam int EATMP = 7, LTMPA = 6, LBTMP = 5;
  localparam int ETMPB = 4, EBA = 3, SU = 2, EU = 1;
  localparam int LO = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  op0, op1;
  logic [5:0]  op2;
  logic [18:0] ctrl0, ctrl1, ctrl2;
  logic [5:0]  ts0, ts2;
  logic [7:0]  ts1;
  logic        done0, done1, done2;
  logic        hlt0, hlt1, hlt2;

  always #5 clk = ~clk;

  sap_param_sequencer #(
    .OPCODE_W(4), .T_MAX(6), .EARLY_END(1'b1),
    .HLT_OPCODE('hF)
  ) u0 (
    .clk(clk), .reset(reset), .run(run),
    .opcode(op0), .ctrl(ctrl0), .t_state(ts0),
    .instr_done(done0), .halted(hlt0)
  );

  sap_param_sequencer #(
    .OPCODE_W(4), .T_MAX(8), .EARLY_END(1'b0),
    .HLT_OPCODE('hF)
  ) u1 (
    .clk(clk), .reset(reset), .run(run),
    .opcode(op1), .ctrl(ctrl1), .t_state(ts1),
    .instr_done(done1), .halted(hlt1)
  );

  sap_param_sequencer #(
    .OPCODE_W(6), .T_MAX(6), .EARLY_END(1'b1),
    .HLT_OPCODE('hF)
  ) u2 (
    .clk(clk), .reset(reset), .run(run),
    .opcode(op2), .ctrl(ctrl2), .t_state(ts2),
    .instr_done(done2), .halted(hlt2)
  );

  typedef struct {
    int          inst;
    logic [18:0] ctrl;
    logic [7:0]  ts;
    logic        done;
    logic        hl;
  } exp_t;

  exp_t sb[$];
  int   mt[3];
  bit   mh[3];
  int   tmax[3] = '{6, 8, 6};
  bit   ee[3]   = '{1'b1, 1'b0, 1'b1};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int opof(input int i);
    if (i == 0) return int'(op0);
    if (i == 1) return int'(op1);
    return int'(op2);
  endfunction

  function automatic int lastof(input int op);
    case (op)
      0: return 5;
      1: return 6;
      4: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [18:0] cw(input int t,
                                     input int op);
    logic [18:0] w;
    w = '0;
    if (t == 1) begin
      w[EP] = 1; w[LMP] = 1;
    end else if (t == 2) begin
      w[CP] = 1;
    end else if (t == 3) begin
      w[CEI] = 1; w[LI] = 1;
    end else begin
      case ({t, op})
        {4, 0}:  begin w[LMI] = 1; w[EI] = 1; end
        {5, 0}:  begin w[CEA] = 1; w[LARAM] = 1; end
        {4, 1}:  begin w[EATMP] = 1; w[LTMPA] = 1; end
        {5, 1}:  begin w[EBA] = 1; w[LAB] = 1; end
        {6, 1}:  begin w[ETMPB] = 1; w[LBTMP] = 1; end
        {4, 2}:  begin w[EU] = 1; w[LALU] = 1; end
        {4, 3}:  begin
          w[SU] = 1; w[EU] = 1; w[LALU] = 1;
        end
        {4, 4}:  begin w[EATMP] = 1; w[LTMPA] = 1; end
        {5, 4}:  begin w[ETMPB] = 1; w[LBTMP] = 1; end
        {4, 14}: w[LO] = 1;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  function automatic bit fin(input int i, input int t,
                             input int op);
    if (t == 4 && op == 15) return 1'b1;
    if (ee[i]) return t == lastof(op);
    return t == tmax[i];
  endfunction

  task automatic push_exp();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      bit   quiet;
      int   op;
      op     = opof(i);
      quiet  = reset || !run || mh[i];
      e.inst = i;
      e.ctrl = quiet ? '0 : cw(mt[i], op);
      e.ts   = mh[i] ? 8'h0 : 8'(1 << (mt[i] - 1));
      e.done = quiet ? 1'b0 : fin(i, mt[i], op);
      e.hl   = mh[i];
      sb.push_back(e);
    end
  endtask

  task automatic pop_cmp();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [18:0] ac;
      logic [7:0]  at;
      logic        ad, ah;
      e = sb.pop_front();
      case (e.inst)
        0: begin
          ac = ctrl0; at = 8'(ts0);
          ad = done0; ah = hlt0;
        end
        1: begin
          ac = ctrl1; at = ts1;
          ad = done1; ah = hlt1;
        end
        default: begin
          ac = ctrl2; at = 8'(ts2);
          ad = done2; ah = hlt2;
        end
      endcase
      chk($sformatf("u%0d.ctrl", e.inst),
          32'(ac), 32'(e.ctrl));
      chk($sformatf("u%0d.t_state", e.inst),
          32'(at), 32'(e.ts));
      chk($sformatf("u%0d.instr_done", e.inst),
          32'(ad), 32'(e.done));
      chk($sformatf("u%0d.halted", e.inst),
          32'(ah), 32'(e.hl));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int op;
      op = opof(i);
      if (reset) begin
        mt[i] = 1;
        mh[i] = 1'b0;
      end else if (!mh[i] && run) begin
        if (mt[i] == 4 && op == 15) begin
          mh[i] = 1'b1;
          mt[i] = 0;
        end else if (fin(i, mt[i], op)) begin
          mt[i] = 1;
        end else begin
          mt[i] = mt[i] + 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit rn);
    reset = r;
    run   = rn;
    push_exp();
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic block(input logic [3:0] a,
                       input logic [3:0] b,
                       input logic [5:0] c,
                       input int n);
    op0 = a; op1 = b; op2 = c;
    cyc(1'b1, 1'b1);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    op0 = 4'h0; op1 = 4'h0; op2 = 6'h0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mt[i] = 1;
      mh[i] = 1'b0;
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1);

    block(4'h1, 4'h1, 6'b010001, 16);
    block(4'h2, 4'h2, 6'h02, 16);
    block(4'h3, 4'h3, 6'h03, 12);
    block(4'h4, 4'h4, 6'h04, 12);
    block(4'hE, 4'hE, 6'h0E, 12);
    block(4'h5, 4'h7, 6'h20, 12);

    op0 = 4'h0; op1 = 4'h0; op2 = 6'h0;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1);

    block(4'hF, 4'hF, 6'h0F, 6);
    for (int k = 0; k < 20; k++) cyc(1'b0, k[0]);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);

    block(4'h1, 4'h1, 6'h01, 4);
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);

    for (int b = 0; b < 10; b++) begin
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
      op2 = 6'($urandom_range(0, 63));
      cyc(1'b1, 1'b1);
      for (int k = 0; k < 20; k++)
        cyc(1'b0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
